// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receive path: FSM states, ASCII codes, gap thresholds.
// No logic; no latency or backpressure of its own.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MARK    = 2'd1,
        ST_GAP     = 2'd2,
        ST_CHARGAP = 2'd3
    } rx_state_t;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
    localparam logic [7:0] ASCII_ETX     = 8'h03;

    localparam int CHARGAP_UNITS = 2;
    localparam int WORDGAP_UNITS = 5;

    localparam logic ELEM_DOT  = 1'b0;
    localparam logic ELEM_DASH = 1'b1;

endpackage

// File: rtl/morse_rx_lut.sv
// Combinational {len, pattern} -> ASCII lookup; first element sits at bit len-1, dash=1.
// Zero latency, no backpressure. MORSE_RX_PROSIGN_EN adds .-.-. (AR) -> ETX.
module morse_rx_lut
    import morse_pkg::*;
(
    input  logic [2:0] len_i,
    input  logic [5:0] pattern_i,
    output logic [7:0] ascii_o,
    output logic       known_o
);

    always_comb begin
        ascii_o = ASCII_UNKNOWN;
        known_o = 1'b1;
        case (len_i)
            3'd1: case (pattern_i)
                6'd0:    ascii_o = 8'h45; // E
                6'd1:    ascii_o = 8'h54; // T
                default: known_o = 1'b0;
            endcase
            3'd2: case (pattern_i)
                6'd0:    ascii_o = 8'h49; // I
                6'd1:    ascii_o = 8'h41; // A
                6'd2:    ascii_o = 8'h4E; // N
                6'd3:    ascii_o = 8'h4D; // M
                default: known_o = 1'b0;
            endcase
            3'd3: case (pattern_i)
                6'd0:    ascii_o = 8'h53; // S
                6'd1:    ascii_o = 8'h55; // U
                6'd2:    ascii_o = 8'h52; // R
                6'd3:    ascii_o = 8'h57; // W
                6'd4:    ascii_o = 8'h44; // D
                6'd5:    ascii_o = 8'h4B; // K
                6'd6:    ascii_o = 8'h47; // G
                6'd7:    ascii_o = 8'h4F; // O
                default: known_o = 1'b0;
            endcase
            3'd4: case (pattern_i)
                6'd0:    ascii_o = 8'h48; // H
                6'd1:    ascii_o = 8'h56; // V
                6'd2:    ascii_o = 8'h46; // F
                6'd4:    ascii_o = 8'h4C; // L
                6'd6:    ascii_o = 8'h50; // P
                6'd7:    ascii_o = 8'h4A; // J
                6'd8:    ascii_o = 8'h42; // B
                6'd9:    ascii_o = 8'h58; // X
                6'd10:   ascii_o = 8'h43; // C
                6'd11:   ascii_o = 8'h59; // Y
                6'd12:   ascii_o = 8'h5A; // Z
                6'd13:   ascii_o = 8'h51; // Q
                default: known_o = 1'b0;
            endcase
            3'd5: case (pattern_i)
                6'd0:    ascii_o = 8'h35;
                6'd1:    ascii_o = 8'h34;
                6'd3:    ascii_o = 8'h33;
                6'd7:    ascii_o = 8'h32;
                6'd15:   ascii_o = 8'h31;
                6'd31:   ascii_o = 8'h30;
                6'd16:   ascii_o = 8'h36;
                6'd24:   ascii_o = 8'h37;
                6'd28:   ascii_o = 8'h38;
                6'd30:   ascii_o = 8'h39;
`ifdef MORSE_RX_PROSIGN_EN
                6'd10:   ascii_o = ASCII_ETX;
`else
                6'd10:   known_o = 1'b0;
`endif
                default: known_o = 1'b0;
            endcase
            default: known_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse line receiver: times marks/spaces in bit-time units, decodes characters, registers ASCII out.
// Code valid 1 cycle after the gap tick; a busy output register drops new codes and pulses OVR.
// MORSE_RX_PROSIGN_EN (in morse_rx_lut) enables AR -> ETX decoding.
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_W   = 3,
    parameter int MAX_ELEM = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic [31:0] BIT_TIME,
    input  logic        INV,
    input  logic        IN,
    output logic [7:0]  DOUT,
    output logic        VALID,
    input  logic        READY,
    output logic        BUSY,
    output logic        ERR,
    output logic        OVR
);

    localparam logic [UNIT_W-1:0] UNITS_MAX = '1;
    localparam logic [UNIT_W-1:0] CG_PRE    = UNIT_W'(CHARGAP_UNITS - 1);
    localparam logic [UNIT_W-1:0] WG_PRE    = UNIT_W'(WORDGAP_UNITS - 1);

    logic              s1_q, s2_q, line_q;
    logic              line, rise, fall, lvl_chg, tick;
    logic [31:0]       bt, cyc_q;
    logic [UNIT_W-1:0] units_q;

    rx_state_t           state_q;
    logic [MAX_ELEM-1:0] pattern_q;
    logic [2:0]          len_q;
    logic                ovf_q, busy_q, valid_q, err_q, ovr_q;
    logic [7:0]          dout_q;

    logic [5:0] lut_pat;
    logic [7:0] lut_ascii;
    logic       lut_known;
    logic       emit_vld, emit_err, elem;
    logic [7:0] emit_dat;

    assign line    = s2_q ^ INV;
    assign rise    = line & ~line_q;
    assign fall    = ~line & line_q;
    assign lvl_chg = line ^ line_q;
    assign bt      = (BIT_TIME == 32'd0) ? 32'd1 : BIT_TIME;
    assign tick    = (cyc_q >= bt - 32'd1);
    assign elem    = (units_q >= UNIT_W'(2)) ? ELEM_DASH : ELEM_DOT;

    // Half-unit preload makes units the rounded length of the current level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            line_q  <= 1'b0;
            cyc_q   <= 32'd0;
            units_q <= '0;
        end else begin
            s1_q   <= IN;
            s2_q   <= s1_q;
            line_q <= line;
            if (lvl_chg) begin
                cyc_q   <= bt >> 1;
                units_q <= '0;
            end else if (tick) begin
                cyc_q <= 32'd0;
                if (units_q != UNITS_MAX)
                    units_q <= units_q + UNIT_W'(1);
            end else begin
                cyc_q <= cyc_q + 32'd1;
            end
        end
    end

    assign lut_pat = 6'(pattern_q);

    morse_rx_lut u_lut (
        .len_i     (len_q),
        .pattern_i (lut_pat),
        .ascii_o   (lut_ascii),
        .known_o   (lut_known)
    );

    always_comb begin
        emit_vld = 1'b0;
        emit_err = 1'b0;
        emit_dat = ASCII_UNKNOWN;
        if (EN && !lvl_chg && tick) begin
            if (state_q == ST_GAP && units_q == CG_PRE && len_q != 3'd0) begin
                emit_vld = 1'b1;
                if (lut_known && !ovf_q)
                    emit_dat = lut_ascii;
                else
                    emit_err = 1'b1;
            end else if (state_q == ST_CHARGAP && units_q == WG_PRE) begin
                emit_vld = 1'b1;
                emit_dat = ASCII_SPACE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            len_q     <= 3'd0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            dout_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            err_q <= emit_vld & emit_err;
            ovr_q <= 1'b0;
            if (emit_vld) begin
                if (valid_q && !READY) begin
                    ovr_q <= 1'b1;
                end else begin
                    dout_q  <= emit_dat;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && READY) begin
                valid_q <= 1'b0;
            end

            if (!EN) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                pattern_q <= '0;
                len_q     <= 3'd0;
                ovf_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (rise) begin
                        state_q   <= ST_MARK;
                        busy_q    <= 1'b1;
                        pattern_q <= '0;
                        len_q     <= 3'd0;
                        ovf_q     <= 1'b0;
                    end
                    ST_MARK: if (fall) begin
                        state_q <= ST_GAP;
                        if (units_q != '0) begin
                            if (len_q == 3'(MAX_ELEM)) begin
                                ovf_q <= 1'b1;
                            end else begin
                                pattern_q <= {pattern_q[MAX_ELEM-2:0], elem};
                                len_q     <= len_q + 3'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (rise)
                            state_q <= ST_MARK;
                        else if (tick && units_q == CG_PRE)
                            state_q <= ST_CHARGAP;
                    end
                    ST_CHARGAP: begin
                        if (rise) begin
                            state_q   <= ST_MARK;
                            pattern_q <= '0;
                            len_q     <= 3'd0;
                            ovf_q     <= 1'b0;
                        end else if (tick && units_q == WG_PRE) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DOUT  = dout_q;
    assign VALID = valid_q;
    assign BUSY  = busy_q;
    assign ERR   = err_q;
    assign OVR   = ovr_q;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder: drives timed Morse waveforms and checks the code stream.
module tb_morse_rx_decoder;

    localparam int U = 20;

    logic        clk, rst, EN, INV, IN, READY;
    logic [31:0] BIT_TIME;
    logic [7:0]  DOUT;
    logic        VALID, BUSY, ERR, OVR;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0, ovr_cnt = 0, pulse_long = 0, pulse_novld = 0;
    logic err_prev = 1'b0, ovr_prev = 1'b0;
    logic [7:0] got[$];

    morse_rx_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .EN       (EN),
        .BIT_TIME (BIT_TIME),
        .INV      (INV),
        .IN       (IN),
        .DOUT     (DOUT),
        .VALID    (VALID),
        .READY    (READY),
        .BUSY     (BUSY),
        .ERR      (ERR),
        .OVR      (OVR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (VALID && READY) got.push_back(DOUT);
            if (ERR) err_cnt++;
            if (OVR) ovr_cnt++;
            if ((ERR && err_prev) || (OVR && ovr_prev)) pulse_long++;
            if ((ERR || OVR) && !VALID) pulse_novld++;
        end
        err_prev = ERR;
        ovr_prev = OVR;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // m=1 is a mark; polarity applied here so waveforms are written in line terms.
    task automatic hold(input logic m, input int cyc);
        IN = m ^ INV;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            hold(1'b1, (s[i] == 8'h2D) ? 3 * U : U);
            if (i != s.len() - 1) hold(1'b0, U);
        end
    endtask

    initial begin
        rst = 1'b1; EN = 1'b0; BIT_TIME = 32'd20; INV = 1'b0; IN = 1'b0; READY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout",  32'(DOUT),  32'h00);
        check("rst_valid", 32'(VALID), 32'd0);
        check("rst_busy",  32'(BUSY),  32'd0);
        check("rst_err",   32'(ERR),   32'd0);
        check("rst_ovr",   32'(OVR),   32'd0);
        rst = 1'b0;
        EN  = 1'b1;
        hold(1'b0, 2 * U);
        check("idle_no_code", 32'(got.size()), 32'd0);
        check("idle_busy",    32'(BUSY),       32'd0);

        // "A" then a character gap only
        send(".-");
        hold(1'b0, 3 * U);
        check("a_count", 32'(got.size()), 32'd1);
        check("a_code",  32'(got[0]),     32'h41);
        check("a_busy",  32'(BUSY),       32'd1);
        hold(1'b0, 4 * U);
        check("a_space_count", 32'(got.size()), 32'd2);
        check("a_space_code",  32'(got[1]),     32'h20);
        check("a_idle_busy",   32'(BUSY),       32'd0);
        got.delete();

        // "AB", word gap, "C", long idle
        send(".-");
        hold(1'b0, 3 * U);
        send("-...");
        hold(1'b0, 7 * U);
        send("-.-.");
        hold(1'b0, 3 * U);
        hold(1'b0, 20 * U);
        check("abc_count", 32'(got.size()), 32'd5);
        check("abc_0", 32'(got[0]), 32'h41);
        check("abc_1", 32'(got[1]), 32'h42);
        check("abc_2", 32'(got[2]), 32'h20);
        check("abc_3", 32'(got[3]), 32'h43);
        check("abc_4", 32'(got[4]), 32'h20);
        got.delete();

        // Active-low line: glitch, then "E"
        EN = 1'b0; INV = 1'b1;
        hold(1'b0, 5);
        EN = 1'b1;
        hold(1'b0, U);
        hold(1'b1, 5);
        hold(1'b0, U);
        hold(1'b1, U);
        hold(1'b0, 3 * U);
        check("inv_count", 32'(got.size()), 32'd1);
        check("inv_e",     32'(got[0]),     32'h45);
        hold(1'b0, 5 * U);
        check("inv_space", 32'(got.size()), 32'd2);
        EN = 1'b0; INV = 1'b0;
        hold(1'b0, 5);
        EN = 1'b1;
        hold(1'b0, U);
        check("err_none_yet", 32'(err_cnt), 32'd0);
        got.delete();

        // Overlong pattern, then AR prosign
        send(".......");
        hold(1'b0, 3 * U);
        check("ovf_code", 32'(got[0]), 32'h3F);
        check("ovf_err",  32'(err_cnt), 32'd1);
        hold(1'b0, 7 * U);
        send(".-.-.");
        hold(1'b0, 3 * U);
`ifdef MORSE_RX_PROSIGN_EN
        check("ar_code", 32'(got[2]), 32'h03);
        check("ar_err",  32'(err_cnt), 32'd1);
`else
        check("ar_code", 32'(got[2]), 32'h3F);
        check("ar_err",  32'(err_cnt), 32'd2);
`endif
        hold(1'b0, 7 * U);
        check("err_count_total", 32'(got.size()), 32'd4);
        check("pulse_width",     32'(pulse_long), 32'd0);
        check("pulse_with_vld",  32'(pulse_novld), 32'd0);
        got.delete();

        // Backpressure: second code dropped with OVR
        READY = 1'b0;
        send(".-");
        hold(1'b0, 3 * U);
        send("-...");
        hold(1'b0, 3 * U);
        check("ovr_cnt",   32'(ovr_cnt),    32'd1);
        check("ovr_valid", 32'(VALID),      32'd1);
        check("ovr_dout",  32'(DOUT),       32'h41);
        check("ovr_none",  32'(got.size()), 32'd0);
        READY = 1'b1;
        hold(1'b0, 2);
        check("ovr_drain_valid", 32'(VALID),      32'd0);
        check("ovr_drain_count", 32'(got.size()), 32'd1);
        check("ovr_drain_code",  32'(got[0]),     32'h41);
        hold(1'b0, 7 * U);
        check("ovr_space", 32'(got[1]),  32'h20);
        check("ovr_once",  32'(ovr_cnt), 32'd1);
        got.delete();

        // Reset in the middle of a dash
        hold(1'b1, 30);
        check("mid_dash_busy", 32'(BUSY), 32'd1);
        rst = 1'b1;
        IN  = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_dout",  32'(DOUT),  32'h00);
        check("mrst_valid", 32'(VALID), 32'd0);
        check("mrst_busy",  32'(BUSY),  32'd0);
        check("mrst_err",   32'(ERR),   32'd0);
        check("mrst_ovr",   32'(OVR),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b0, 7 * U);
        check("mrst_no_code", 32'(got.size()), 32'd0);
        check("mrst_idle",    32'(BUSY),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
